// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RISC-V style datapath (LW, SW, R-type, BEQ).
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT state.
module multicycle_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       ALUSrcA,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_RWB      = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic       run_q;
    logic       illegal_d;
    logic [1:0] alu_op_d,  alu_op_q;
    logic [1:0] src_b_d,   src_b_q;
    logic       src_a_d,   src_a_q;
    logic       mem_rd_d,  mem_rd_q;
    logic       mem_wr_d,  mem_wr_q;
    logic       iord_d,    iord_q;
    logic       ir_wr_d,   ir_wr_q;
    logic       reg_wr_d,  reg_wr_q;
    logic       m2r_d,     m2r_q;
    logic       pc_wr_d,   pc_wr_q;
    logic       pc_wc_d,   pc_wc_q;
    logic       pc_src_d,  pc_src_q;

    // Next-state selection; opcode only matters in DECODE and MEMADDR.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE:     state_d = run_q ? S_FETCH : S_IDLE;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = S_FETCH;
                        illegal_d = 1'b0;
`endif
                    end
                endcase
            end
            S_MEMADDR:  state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTE:  state_d = S_RWB;
            S_RWB:      state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase
    end

    // Control decode of the upcoming state so the registered outputs track state_q.
    always_comb begin
        alu_op_d = 2'b00;
        src_b_d  = 2'b00;
        src_a_d  = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        iord_d   = 1'b0;
        ir_wr_d  = 1'b0;
        reg_wr_d = 1'b0;
        m2r_d    = 1'b0;
        pc_wr_d  = 1'b0;
        pc_wc_d  = 1'b0;
        pc_src_d = 1'b0;
        case (state_d)
            S_FETCH: begin
                mem_rd_d = 1'b1;
                ir_wr_d  = 1'b1;
                src_b_d  = 2'b01;
                pc_wr_d  = 1'b1;
            end
            S_DECODE:   src_b_d = 2'b11;
            S_MEMADDR: begin
                src_a_d = 1'b1;
                src_b_d = 2'b10;
            end
            S_MEMREAD: begin
                mem_rd_d = 1'b1;
                iord_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_wr_d = 1'b1;
                m2r_d    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_wr_d = 1'b1;
                iord_d   = 1'b1;
            end
            S_EXECUTE: begin
                src_a_d  = 1'b1;
                alu_op_d = 2'b10;
            end
            S_RWB:      reg_wr_d = 1'b1;
            S_BRANCH: begin
                src_a_d  = 1'b1;
                alu_op_d = 2'b01;
                pc_wc_d  = 1'b1;
                pc_src_d = 1'b1;
            end
            default: begin
                alu_op_d = 2'b00;
            end
        endcase
    end

    // State, start-delay flag and registered control outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            alu_op_q <= 2'b00;
            src_b_q  <= 2'b00;
            src_a_q  <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            iord_q   <= 1'b0;
            ir_wr_q  <= 1'b0;
            reg_wr_q <= 1'b0;
            m2r_q    <= 1'b0;
            pc_wr_q  <= 1'b0;
            pc_wc_q  <= 1'b0;
            pc_src_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            alu_op_q <= alu_op_d;
            src_b_q  <= src_b_d;
            src_a_q  <= src_a_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            iord_q   <= iord_d;
            ir_wr_q  <= ir_wr_d;
            reg_wr_q <= reg_wr_d;
            m2r_q    <= m2r_d;
            pc_wr_q  <= pc_wr_d;
            pc_wc_q  <= pc_wc_d;
            pc_src_q <= pc_src_d;
        end
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_q | illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    logic unused_s;
    assign unused_s = illegal_d;
    assign illegal  = 1'b0;
`endif

    assign ALUOp       = alu_op_q;
    assign ALUSrcB     = src_b_q;
    assign ALUSrcA     = src_a_q;
    assign MemRead     = mem_rd_q;
    assign MemWrite    = mem_wr_q;
    assign IorD        = iord_q;
    assign IRWrite     = ir_wr_q;
    assign RegWrite    = reg_wr_q;
    assign MemtoReg    = m2r_q;
    assign PCWrite     = pc_wr_q;
    assign PCWriteCond = pc_wc_q;
    assign PCSource    = pc_src_q;
    assign state       = state_q;

endmodule
